// File: rtl/flopdiv_seq_if.sv
// Start/busy/done bus of the FP32 divider: operands in, quotient and exception flags out.
// The master drives start and operands; the slave (divider) returns status and result.
interface flopdiv_seq_if;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        div_zero;
  logic        invalid;

  modport master (
    output start, dividend, divisor,
    input  busy, done, result, div_zero, invalid
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, result, div_zero, invalid
  );
endinterface

// File: rtl/flopdiv_seq.sv
// Iterative FP32 divider (restoring, 1 quotient bit/cycle, FTZ, canonical NaN); done 27 edges after capture
// (2 for specials), start ignored while busy. FLOPDIV_ROUND_NEAREST_EN: guard+sticky RNE, 28 edges.
module flopdiv_seq (
  input  logic         clk,
  input  logic         rst,
  flopdiv_seq_if.slave bus
);

`ifdef FLOPDIV_ROUND_NEAREST_EN
  localparam int QW = 26;
`else
  localparam int QW = 25;
`endif
  localparam logic [4:0] ITER_LAST = 5'(QW - 1);

  typedef enum logic [1:0] {IDLE, DIVIDE, NORM} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_sign;
  logic signed [9:0]  r_e;
  logic [23:0]        r_m2;
  logic [24:0]        r_rem;
  logic [QW-1:0]      r_q;
  logic [4:0]         r_cnt;
  logic               r_phase;
  logic               r_spec;
  logic [31:0]        r_spec_res;
  logic               r_spec_dz;
  logic               r_spec_inv;
  logic [22:0]        r_frac;
  logic [31:0]        r_result;
  logic               r_done;
  logic               r_dz;
  logic               r_inv;

  // Operand classification on the capture cycle
  logic [7:0]  w_e1, w_e2;
  logic [22:0] w_f1, w_f2;
  logic        w_s;
  logic        w_z1, w_z2, w_n1, w_n2, w_i1, w_i2;
  logic        w_is_spec;
  logic [31:0] w_spec_res;
  logic        w_spec_dz;
  logic        w_spec_inv;
  logic signed [9:0] w_e_calc;
  logic        w_start_ok;

  assign w_e1 = bus.dividend[30:23];
  assign w_e2 = bus.divisor[30:23];
  assign w_f1 = bus.dividend[22:0];
  assign w_f2 = bus.divisor[22:0];
  assign w_s  = bus.dividend[31] ^ bus.divisor[31];
  assign w_z1 = (w_e1 == 8'd0);
  assign w_z2 = (w_e2 == 8'd0);
  assign w_n1 = (w_e1 == 8'hFF) && (w_f1 != 23'd0);
  assign w_n2 = (w_e2 == 8'hFF) && (w_f2 != 23'd0);
  assign w_i1 = (w_e1 == 8'hFF) && (w_f1 == 23'd0);
  assign w_i2 = (w_e2 == 8'hFF) && (w_f2 == 23'd0);
  assign w_e_calc   = $signed({2'b00, w_e1}) - $signed({2'b00, w_e2}) + 10'sd127;
  assign w_start_ok = bus.start && (r_state == IDLE);

  always_comb begin
    w_is_spec  = 1'b1;
    w_spec_res = {w_s, 31'd0};
    w_spec_dz  = 1'b0;
    w_spec_inv = 1'b0;
    if (w_n1 || w_n2 || (w_z1 && w_z2) || (w_i1 && w_i2)) begin
      w_spec_res = {w_s, 8'hFF, 23'h7FFFFF};
      w_spec_inv = 1'b1;
    end else if (w_i1 || w_z2) begin
      w_spec_res = {w_s, 8'hFF, 23'd0};
      w_spec_dz  = w_z2;
    end else if (w_z1 || w_i2) begin
      w_spec_res = {w_s, 31'd0};
    end else begin
      w_is_spec = 1'b0;
    end
  end

  // Restoring step: remainder stays below m2 after subtraction, so 24 bits survive the shift
  logic        w_ge;
  logic [24:0] w_rem_sub;
  logic [24:0] w_rem_nxt;

  assign w_ge      = (r_rem >= {1'b0, r_m2});
  assign w_rem_sub = w_ge ? (r_rem - {1'b0, r_m2}) : r_rem;
  assign w_rem_nxt = {w_rem_sub[23:0], 1'b0};

  logic [22:0]       w_frac;
  logic signed [9:0] w_e_norm;

`ifdef FLOPDIV_ROUND_NEAREST_EN
  logic [23:0]       w_m24;
  logic              w_guard;
  logic              w_sticky;
  logic              w_inc;
  logic [24:0]       w_sum;
  logic signed [9:0] w_e_pre;

  always_comb begin
    if (r_q[25]) begin
      w_m24    = r_q[25:2];
      w_guard  = r_q[1];
      w_sticky = r_q[0] || (r_rem != 25'd0);
      w_e_pre  = r_e;
    end else begin
      w_m24    = r_q[24:1];
      w_guard  = r_q[0];
      w_sticky = (r_rem != 25'd0);
      w_e_pre  = r_e - 10'sd1;
    end
    w_inc = w_guard && (w_sticky || w_m24[0]);
    w_sum = {1'b0, w_m24} + {24'd0, w_inc};
    if (w_sum[24]) begin
      w_frac   = w_sum[23:1];
      w_e_norm = w_e_pre + 10'sd1;
    end else begin
      w_frac   = w_sum[22:0];
      w_e_norm = w_e_pre;
    end
  end
`else
  always_comb begin
    if (r_q[24]) begin
      w_frac   = r_q[23:1];
      w_e_norm = r_e;
    end else begin
      w_frac   = r_q[22:0];
      w_e_norm = r_e - 10'sd1;
    end
  end
`endif

  logic [31:0] w_packed;

  always_comb begin
    if (r_e >= 10'sd255) begin
      w_packed = {r_sign, 8'hFF, 23'd0};
    end else if (r_e <= 10'sd0) begin
      w_packed = {r_sign, 31'd0};
    end else begin
      w_packed = {r_sign, r_e[7:0], r_frac};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start_ok) w_state_nxt = w_is_spec ? NORM : DIVIDE;
      DIVIDE:  if (r_cnt == ITER_LAST) w_state_nxt = NORM;
      NORM:    if (r_phase) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NORM spans two cycles: normalise/round into r_e/r_frac, then range-check and publish
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sign     <= 1'b0;
      r_e        <= 10'sd0;
      r_m2       <= 24'd0;
      r_rem      <= 25'd0;
      r_q        <= '0;
      r_cnt      <= 5'd0;
      r_phase    <= 1'b0;
      r_spec     <= 1'b0;
      r_spec_res <= 32'd0;
      r_spec_dz  <= 1'b0;
      r_spec_inv <= 1'b0;
      r_frac     <= 23'd0;
      r_result   <= 32'd0;
      r_done     <= 1'b0;
      r_dz       <= 1'b0;
      r_inv      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start_ok) begin
            r_sign     <= w_s;
            r_e        <= w_e_calc;
            r_m2       <= {1'b1, w_f2};
            r_rem      <= {2'b01, w_f1};
            r_q        <= '0;
            r_cnt      <= 5'd0;
            r_phase    <= 1'b0;
            r_spec     <= w_is_spec;
            r_spec_res <= w_spec_res;
            r_spec_dz  <= w_spec_dz;
            r_spec_inv <= w_spec_inv;
          end
        end
        DIVIDE: begin
          r_rem <= w_rem_nxt;
          r_q   <= {r_q[QW-2:0], w_ge};
          r_cnt <= r_cnt + 5'd1;
        end
        NORM: begin
          if (!r_phase) begin
            r_phase <= 1'b1;
            if (!r_spec) begin
              r_frac <= w_frac;
              r_e    <= w_e_norm;
            end
          end else begin
            r_phase  <= 1'b0;
            r_done   <= 1'b1;
            r_result <= r_spec ? r_spec_res : w_packed;
            r_dz     <= r_spec && r_spec_dz;
            r_inv    <= r_spec && r_spec_inv;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (r_state != IDLE);
  assign bus.done     = r_done;
  assign bus.result   = r_result;
  assign bus.div_zero = r_dz;
  assign bus.invalid  = r_inv;

endmodule

// File: tb/tb_flopdiv_seq.sv
// Directed bench for flopdiv_seq: hand-computed quotients, flags and done latency per operation,
// plus start-while-busy and mid-operation reset.
module tb_flopdiv_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  flopdiv_seq_if u_if ();

  flopdiv_seq u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  int n_cmp = 0;
  int n_err = 0;

`ifdef FLOPDIV_ROUND_NEAREST_EN
  localparam int          LAT_N = 28;
  localparam logic [31:0] THIRD = 32'h3EAAAAAB;
`else
  localparam int          LAT_N = 27;
  localparam logic [31:0] THIRD = 32'h3EAAAAAA;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Issue one operation; glitch re-pulses start with other operands at edge 10.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_dz, input logic exp_inv,
                        input int exp_lat, input bit glitch);
    int lat;
    @(negedge clk);
    u_if.dividend = a;
    u_if.divisor  = b;
    u_if.start    = 1'b1;
    @(posedge clk);
    #1;
    u_if.start = 1'b0;
    chk({tag, "_busy"}, u_if.busy, 1'b1);
    lat = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk);
      #1;
      if (u_if.done) begin
        lat = n;
        break;
      end
      if (glitch && n == 9) begin
        u_if.dividend = 32'h3F800000;
        u_if.divisor  = 32'h00000000;
        u_if.start    = 1'b1;
      end
      if (glitch && n == 10) u_if.start = 1'b0;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_res"}, u_if.result, exp_res);
    chk({tag, "_dz"}, u_if.div_zero, exp_dz);
    chk({tag, "_inv"}, u_if.invalid, exp_inv);
    chk({tag, "_busy_done"}, u_if.busy, 1'b0);
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, u_if.done, 1'b0);
    chk({tag, "_hold"}, u_if.result, exp_res);
    if (glitch) chk({tag, "_noqueue"}, u_if.busy, 1'b0);
  endtask

  initial begin
    bit seen;
    rst           = 1'b1;
    u_if.start    = 1'b0;
    u_if.dividend = 32'd0;
    u_if.divisor  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", u_if.busy, 1'b0);
    chk("rst_done", u_if.done, 1'b0);
    chk("rst_res", u_if.result, 32'd0);
    chk("rst_dz", u_if.div_zero, 1'b0);
    chk("rst_inv", u_if.invalid, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    run_op("6div2",    32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, LAT_N, 1'b0);
    run_op("1div3",    32'h3F800000, 32'h40400000, THIRD,        1'b0, 1'b0, LAT_N, 1'b0);
    run_op("1div0",    32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 1'b0, 2,     1'b0);
    run_op("0div0",    32'h00000000, 32'h00000000, 32'h7FFFFFFF, 1'b0, 1'b1, 2,     1'b0);
    run_op("ninfdiv2", 32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 1'b0, 2,     1'b0);
    run_op("ovf",      32'h7F000000, 32'h00800000, 32'h7F800000, 1'b0, 1'b0, LAT_N, 1'b0);
    run_op("unf",      32'h00800000, 32'h7F000000, 32'h00000000, 1'b0, 1'b0, LAT_N, 1'b0);
    run_op("denorm",   32'h00400000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, 2,     1'b0);
    run_op("nan_in",   32'h7FC00000, 32'h3F800000, 32'h7FFFFFFF, 1'b0, 1'b1, 2,     1'b0);
    run_op("ninf_inf", 32'hFF800000, 32'h7F800000, 32'hFFFFFFFF, 1'b0, 1'b1, 2,     1'b0);
    run_op("fin_inf",  32'hC0000000, 32'h7F800000, 32'h80000000, 1'b0, 1'b0, 2,     1'b0);
    run_op("neg",      32'h3FC00000, 32'hBF800000, 32'hBFC00000, 1'b0, 1'b0, LAT_N, 1'b0);
    run_op("ignore",   32'h40C00000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, LAT_N, 1'b1);
    run_op("1div0b",   32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 1'b0, 2,     1'b0);

    // Abort a normal-path operation with reset at edge 12
    @(negedge clk);
    u_if.dividend = 32'h3F800000;
    u_if.divisor  = 32'h40400000;
    u_if.start    = 1'b1;
    @(posedge clk);
    #1;
    u_if.start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("pre_rst_busy", u_if.busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("arst_busy", u_if.busy, 1'b0);
    chk("arst_done", u_if.done, 1'b0);
    chk("arst_res", u_if.result, 32'd0);
    chk("arst_dz", u_if.div_zero, 1'b0);
    chk("arst_inv", u_if.invalid, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (u_if.done || u_if.busy) seen = 1'b1;
    end
    chk("arst_no_done", seen, 1'b0);
    run_op("post_rst", 32'h3F800000, 32'h40400000, THIRD, 1'b0, 1'b0, LAT_N, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
